// File: rtl/sig_relation_monitor_pkg.sv
// Shared types for the signal-relation monitor: per-channel relation codes and FSM states.
package sig_mon_pkg;

  typedef enum logic [1:0] {REL_AND, REL_OR, REL_EQ, REL_NEQ} rel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_ACTIVE, ST_HALTED} mon_state_e;

  // Index width for a channel number; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_relation_monitor_if.sv
// Bundle between the monitored environment (master) and the relation monitor (slave).
interface sig_relation_monitor_if
  import sig_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16
);

  localparam int CH_W = idx_w(NUM_CH);

  logic                    arm;
  logic                    clear;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       a;
  logic [NUM_CH-1:0]       b;
  logic [NUM_CH-1:0]       fail_pulse;
  logic [NUM_CH-1:0]       fail_sticky;
  logic [NUM_CH*CNT_W-1:0] fail_cnt;
  logic                    any_fail;
  logic [CH_W-1:0]         first_ch;
  logic [TS_W-1:0]         first_ts;
  logic [TS_W-1:0]         sample_cnt;
  logic [1:0]              state;

  modport master (
    output arm, clear, mode, a, b,
    input  fail_pulse, fail_sticky, fail_cnt, any_fail, first_ch, first_ts, sample_cnt, state
  );

  modport slave (
    input  arm, clear, mode, a, b,
    output fail_pulse, fail_sticky, fail_cnt, any_fail, first_ch, first_ts, sample_cnt, state
  );

endinterface

// File: rtl/sig_relation_monitor_chan.sv
// One monitored channel: relation check, registered fail pulse, sticky flag, saturating counter.
module sig_mon_chan
  import sig_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check,
  input  logic             clear,
  input  rel_e             mode,
  input  logic             a,
  input  logic             b,
  output logic             viol,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_cnt
);

  logic rel_ok;

  always_comb begin
    rel_ok = 1'b1;
    case (mode)
      REL_AND: rel_ok = a & b;
      REL_OR:  rel_ok = a | b;
      REL_EQ:  rel_ok = ~(a ^ b);
      REL_NEQ: rel_ok = a ^ b;
      default: rel_ok = 1'b1;
    endcase
  end

  assign viol = check & ~rel_ok;

  // check already excludes a clearing cycle, so a clear always wins over a violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_pulse  <= 1'b0;
      fail_sticky <= 1'b0;
      fail_cnt    <= '0;
    end else if (clear) begin
      fail_pulse  <= 1'b0;
      fail_sticky <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      fail_pulse <= viol;
      if (viol) begin
        fail_sticky <= 1'b1;
        if (fail_cnt != '1)
          fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sig_relation_monitor.sv
// Runtime relation checker: arm/warm-up FSM, sample counter and first-failure capture
// around NUM_CH per-channel checkers.
module sig_relation_monitor
  import sig_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int TS_W         = 16,
  parameter int WARMUP       = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sig_relation_monitor_if.slave mon
);

  localparam int CH_W   = idx_w(NUM_CH);
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [TS_W-1:0] TS_MAX = '1;

  mon_state_e              state, state_nxt;
  logic [WARM_W-1:0]       warm_cnt, warm_nxt;
  logic                    check;
  logic [NUM_CH-1:0]       viol;
  logic                    any_viol;
  logic [CH_W-1:0]         first_idx;
  logic                    first_vld;
  logic [CH_W-1:0]         first_ch;
  logic [TS_W-1:0]         first_ts;
  logic [TS_W-1:0]         sample_cnt;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       sticky;
  logic [NUM_CH*CNT_W-1:0] cnt;

  assign check    = (state == ST_ACTIVE) && mon.arm && !mon.clear;
  assign any_viol = |viol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_nxt;
    end
  end

  // The arming edge is the first ignored sample, so WARMUP holds for WARMUP-1 further edges.
  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    if (!mon.arm) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (WARMUP > 1) begin
            state_nxt = ST_WARMUP;
            warm_nxt  = WARM_W'(WARMUP - 2);
          end else begin
            state_nxt = ST_ACTIVE;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == '0)
            state_nxt = ST_ACTIVE;
          else
            warm_nxt = warm_cnt - 1'b1;
        end
        ST_ACTIVE:  if ((STOP_ON_FAIL != 0) && any_viol) state_nxt = ST_HALTED;
        ST_HALTED:  if (mon.clear) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (viol[i]) first_idx = CH_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      first_vld  <= 1'b0;
      first_ch   <= '0;
      first_ts   <= '0;
    end else if (mon.clear) begin
      sample_cnt <= '0;
      first_vld  <= 1'b0;
      first_ch   <= '0;
      first_ts   <= '0;
    end else if (check) begin
      if (sample_cnt != TS_MAX)
        sample_cnt <= sample_cnt + 1'b1;
      if (any_viol && !first_vld) begin
        first_vld <= 1'b1;
        first_ch  <= first_idx;
        first_ts  <= sample_cnt;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sig_mon_chan #(.CNT_W(CNT_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .check       (check),
      .clear       (mon.clear),
      .mode        (rel_e'(mon.mode[2*g +: 2])),
      .a           (mon.a[g]),
      .b           (mon.b[g]),
      .viol        (viol[g]),
      .fail_pulse  (pulse[g]),
      .fail_sticky (sticky[g]),
      .fail_cnt    (cnt[g*CNT_W +: CNT_W])
    );
  end

  assign mon.fail_pulse  = pulse;
  assign mon.fail_sticky = sticky;
  assign mon.fail_cnt    = cnt;
  assign mon.any_fail    = |sticky;
  assign mon.first_ch    = first_ch;
  assign mon.first_ts    = first_ts;
  assign mon.sample_cnt  = sample_cnt;
  assign mon.state       = state;

endmodule

// File: tb/tb_sig_relation_monitor.sv
// Bench for sig_relation_monitor: three configurations (default, CNT_W=2, STOP_ON_FAIL=1)
// share one stimulus stream and are compared against a behavioural reference model.
module tb_sig_relation_monitor;

  localparam int WARM = 2;

  logic       clk;
  logic       rst;
  logic       arm;
  logic       clear;
  logic [7:0] mode;
  logic [3:0] a;
  logic [3:0] b;

  int checks;
  int errors;

  sig_relation_monitor_if #(.NUM_CH(4), .CNT_W(8), .TS_W(16)) if0 ();
  sig_relation_monitor_if #(.NUM_CH(4), .CNT_W(2), .TS_W(16)) if1 ();
  sig_relation_monitor_if #(.NUM_CH(4), .CNT_W(8), .TS_W(16)) if2 ();

  sig_relation_monitor #(.NUM_CH(4), .CNT_W(8), .TS_W(16), .WARMUP(WARM), .STOP_ON_FAIL(0))
    u_dut0 (.clk(clk), .rst(rst), .mon(if0));
  sig_relation_monitor #(.NUM_CH(4), .CNT_W(2), .TS_W(16), .WARMUP(WARM), .STOP_ON_FAIL(0))
    u_dut1 (.clk(clk), .rst(rst), .mon(if1));
  sig_relation_monitor #(.NUM_CH(4), .CNT_W(8), .TS_W(16), .WARMUP(WARM), .STOP_ON_FAIL(1))
    u_dut2 (.clk(clk), .rst(rst), .mon(if2));

  assign if0.arm = arm;  assign if0.clear = clear;  assign if0.mode = mode;  assign if0.a = a;  assign if0.b = b;
  assign if1.arm = arm;  assign if1.clear = clear;  assign if1.mode = mode;  assign if1.a = a;  assign if1.b = b;
  assign if2.arm = arm;  assign if2.clear = clear;  assign if2.mode = mode;  assign if2.a = a;  assign if2.b = b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed outputs gathered per instance so the three configurations can be looped over.
  logic [3:0]  o_pulse  [3];
  logic [3:0]  o_sticky [3];
  logic [7:0]  o_cnt    [3][4];
  logic        o_any    [3];
  logic [1:0]  o_fch    [3];
  logic [15:0] o_fts    [3];
  logic [15:0] o_scnt   [3];
  logic [1:0]  o_state  [3];

  always_comb begin
    o_pulse[0] = if0.fail_pulse;   o_pulse[1] = if1.fail_pulse;   o_pulse[2] = if2.fail_pulse;
    o_sticky[0] = if0.fail_sticky; o_sticky[1] = if1.fail_sticky; o_sticky[2] = if2.fail_sticky;
    o_any[0] = if0.any_fail;       o_any[1] = if1.any_fail;       o_any[2] = if2.any_fail;
    o_fch[0] = if0.first_ch;       o_fch[1] = if1.first_ch;       o_fch[2] = if2.first_ch;
    o_fts[0] = if0.first_ts;       o_fts[1] = if1.first_ts;       o_fts[2] = if2.first_ts;
    o_scnt[0] = if0.sample_cnt;    o_scnt[1] = if1.sample_cnt;    o_scnt[2] = if2.sample_cnt;
    o_state[0] = if0.state;        o_state[1] = if1.state;        o_state[2] = if2.state;
    for (int i = 0; i < 4; i++) begin
      o_cnt[0][i] = if0.fail_cnt[i*8 +: 8];
      o_cnt[1][i] = {6'd0, if1.fail_cnt[i*2 +: 2]};
      o_cnt[2][i] = if2.fail_cnt[i*8 +: 8];
    end
  end

  // Reference model: 0 idle, 1 warm-up, 2 active, 3 halted.
  int         cnt_max  [3] = '{255, 3, 255};
  bit         stop_cfg [3] = '{1'b0, 1'b0, 1'b1};
  int         m_state  [3];
  int         m_edges  [3];
  int         m_cnt    [3][4];
  logic [3:0] m_pulse  [3];
  logic [3:0] m_sticky [3];
  bit         m_fvld   [3];
  int         m_fch    [3];
  int         m_fts    [3];
  int         m_scnt   [3];

  function automatic bit rel_holds(input logic [1:0] m, input logic x, input logic y);
    case (m)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x == y;
      default: return x != y;
    endcase
  endfunction

  task automatic model_clear_stats(input int k);
    m_pulse[k] = '0;  m_sticky[k] = '0;  m_fvld[k] = 1'b0;
    m_fch[k] = 0;     m_fts[k] = 0;      m_scnt[k] = 0;
    for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      model_clear_stats(k);
      m_state[k] = 0;
      m_edges[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit         chk;
      int         low;
      logic [3:0] v;
      chk = (m_state[k] == 2) && arm && !clear;
      v   = '0;
      low = -1;
      for (int i = 0; i < 4; i++) begin
        if (chk && !rel_holds(mode[2*i +: 2], a[i], b[i])) begin
          v[i] = 1'b1;
          if (low < 0) low = i;
        end
      end
      if (clear) begin
        model_clear_stats(k);
      end else begin
        m_pulse[k]  = v;
        m_sticky[k] = m_sticky[k] | v;
        for (int i = 0; i < 4; i++)
          if (v[i] && m_cnt[k][i] < cnt_max[k]) m_cnt[k][i]++;
        if (low >= 0 && !m_fvld[k]) begin
          m_fvld[k] = 1'b1;
          m_fch[k]  = low;
          m_fts[k]  = m_scnt[k];
        end
        if (chk && m_scnt[k] < 65535) m_scnt[k]++;
      end
      if (!arm) begin
        m_state[k] = 0;
      end else begin
        case (m_state[k])
          0: begin m_edges[k] = 1; m_state[k] = (WARM > 1) ? 1 : 2; end
          1: begin m_edges[k]++; if (m_edges[k] >= WARM) m_state[k] = 2; end
          2: if (stop_cfg[k] && low >= 0) m_state[k] = 3;
          3: if (clear) m_state[k] = 0;
          default: m_state[k] = 0;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Drop arm with a clear, then re-arm and ride out the warm-up so every instance is ACTIVE.
  task automatic rearm();
    arm = 1'b0; clear = 1'b1; tick();
    arm = 1'b1; clear = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_state[k] !== 2'd0) begin errors++; $display("[TB] FAIL reset_state inst%0d got %0d exp 0", k, o_state[k]); end
      checks++; if (o_scnt[k] !== 16'd0) begin errors++; $display("[TB] FAIL reset_scnt inst%0d got %0d exp 0", k, o_scnt[k]); end
      checks++; if (o_any[k] !== 1'b0 || o_sticky[k] !== 4'd0 || o_pulse[k] !== 4'd0) begin errors++; $display("[TB] FAIL reset_flags inst%0d got any=%0b sticky=%0h pulse=%0h exp 0", k, o_any[k], o_sticky[k], o_pulse[k]); end
      checks++; if ({o_cnt[k][0], o_cnt[k][1], o_cnt[k][2], o_cnt[k][3]} !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt inst%0d got nonzero exp 0", k); end
      checks++; if (o_fts[k] !== 16'd0 || o_fch[k] !== 2'd0) begin errors++; $display("[TB] FAIL reset_first inst%0d got ch=%0d ts=%0d exp 0", k, o_fch[k], o_fts[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_pass();
    arm = 1'b1; mode = 8'h00; a = 4'hF; b = 4'hF;
    repeat (10) tick();
    checks++; if (o_scnt[0] !== 16'd8) begin errors++; $display("[TB] FAIL pass_scnt got %0d exp 8", o_scnt[0]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_state[k] !== 2'd2) begin errors++; $display("[TB] FAIL pass_state inst%0d got %0d exp 2", k, o_state[k]); end
      checks++; if (o_any[k] !== 1'b0 || o_scnt[k] !== 16'(m_scnt[k])) begin errors++; $display("[TB] FAIL pass_stats inst%0d got any=%0b scnt=%0d exp any=0 scnt=%0d", k, o_any[k], o_scnt[k], m_scnt[k]); end
    end
  endtask

  task automatic test_first_fail();
    clear = 1'b1; tick(); clear = 1'b0;
    mode = 8'b00_00_01_00; a = 4'hF; b = 4'hF;
    tick(); tick();
    a = 4'b1101; b = 4'b1101;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_pulse[k] !== 4'b0010) begin errors++; $display("[TB] FAIL ff_pulse inst%0d got %0h exp 2", k, o_pulse[k]); end
      checks++; if (o_cnt[k][1] !== 8'd1) begin errors++; $display("[TB] FAIL ff_cnt1 inst%0d got %0d exp 1", k, o_cnt[k][1]); end
      checks++; if (o_fch[k] !== 2'd1 || o_fts[k] !== 16'd2) begin errors++; $display("[TB] FAIL ff_capture inst%0d got ch=%0d ts=%0d exp ch=1 ts=2", k, o_fch[k], o_fts[k]); end
    end
    checks++; if (o_state[2] !== 2'd3) begin errors++; $display("[TB] FAIL ff_halt got %0d exp 3", o_state[2]); end
    a = 4'hF; b = 4'hF;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_pulse[k] !== 4'b0000) begin errors++; $display("[TB] FAIL ff_pulse_width inst%0d got %0h exp 0", k, o_pulse[k]); end
    end
  endtask

  task automatic test_simultaneous();
    rearm();
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_state[k] !== 2'd2) begin errors++; $display("[TB] FAIL sim_armed inst%0d got %0d exp 2", k, o_state[k]); end
    end
    mode = 8'h00; a = 4'b0110; b = 4'hF;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_fch[k] !== 2'd0 || o_fts[k] !== 16'd0) begin errors++; $display("[TB] FAIL sim_capture inst%0d got ch=%0d ts=%0d exp ch=0 ts=0", k, o_fch[k], o_fts[k]); end
      checks++; if (o_cnt[k][0] !== 8'd1 || o_cnt[k][3] !== 8'd1 || o_cnt[k][1] !== 8'd0) begin errors++; $display("[TB] FAIL sim_cnt inst%0d got c0=%0d c1=%0d c3=%0d exp 1 0 1", k, o_cnt[k][0], o_cnt[k][1], o_cnt[k][3]); end
      checks++; if (o_pulse[k] !== 4'b1001) begin errors++; $display("[TB] FAIL sim_pulse inst%0d got %0h exp 9", k, o_pulse[k]); end
    end
    a = 4'hF;
  endtask

  task automatic test_saturation();
    rearm();
    mode = 8'b00_11_00_00; a = 4'hF; b = 4'hF;
    repeat (6) tick();
    checks++; if (o_cnt[1][2] !== 8'd3 || o_sticky[1][2] !== 1'b1) begin errors++; $display("[TB] FAIL sat_cnt2 got cnt=%0d sticky=%0b exp cnt=3 sticky=1", o_cnt[1][2], o_sticky[1][2]); end
    checks++; if (o_cnt[0][2] !== 8'd6) begin errors++; $display("[TB] FAIL sat_wide got %0d exp 6", o_cnt[0][2]); end
    checks++; if (o_cnt[2][2] !== 8'd1 || o_state[2] !== 2'd3) begin errors++; $display("[TB] FAIL sat_halted got cnt=%0d state=%0d exp cnt=1 state=3", o_cnt[2][2], o_state[2]); end
    mode = 8'h00;
  endtask

  task automatic test_halt();
    rearm();
    mode = 8'h00; a = 4'hF; b = 4'hF;
    tick();
    a = 4'b1110;
    tick();
    checks++; if (o_state[2] !== 2'd3) begin errors++; $display("[TB] FAIL halt_enter got %0d exp 3", o_state[2]); end
    repeat (3) tick();
    checks++; if (o_cnt[2][0] !== 8'd1 || o_scnt[2] !== 16'd2 || o_fts[2] !== 16'd1) begin errors++; $display("[TB] FAIL halt_frozen got cnt=%0d scnt=%0d ts=%0d exp 1 2 1", o_cnt[2][0], o_scnt[2], o_fts[2]); end
    checks++; if (o_cnt[0][0] !== 8'd4) begin errors++; $display("[TB] FAIL halt_free_run got %0d exp 4", o_cnt[0][0]); end
    a = 4'hF; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (o_state[2] !== 2'd0) begin errors++; $display("[TB] FAIL halt_clear_state got %0d exp 0", o_state[2]); end
    checks++; if (o_cnt[2][0] !== 8'd0 || o_scnt[2] !== 16'd0 || o_any[2] !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear_stats got cnt=%0d scnt=%0d any=%0b exp 0", o_cnt[2][0], o_scnt[2], o_any[2]); end
    checks++; if (o_state[0] !== 2'd2) begin errors++; $display("[TB] FAIL clear_keeps_active got %0d exp 2", o_state[0]); end
  endtask

  task automatic test_arm_drop();
    rearm();
    mode = 8'h00; a = 4'b0111; b = 4'hF;
    tick(); tick();
    arm = 1'b0;
    tick();
    checks++; if (o_state[0] !== 2'd0 || o_cnt[0][3] !== 8'd2 || o_sticky[0] !== 4'b1000) begin errors++; $display("[TB] FAIL drop_retain got state=%0d cnt=%0d sticky=%0h exp 0 2 8", o_state[0], o_cnt[0][3], o_sticky[0]); end
    arm = 1'b1;
    tick();
    checks++; if (o_state[0] !== 2'd1 || o_cnt[0][3] !== 8'd2) begin errors++; $display("[TB] FAIL drop_rewarm got state=%0d cnt=%0d exp 1 2", o_state[0], o_cnt[0][3]); end
    tick(); tick();
    checks++; if (o_cnt[0][3] !== 8'd3) begin errors++; $display("[TB] FAIL drop_resume got %0d exp 3", o_cnt[0][3]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_cnt[k][3] !== 8'(m_cnt[k][3]) || o_state[k] !== 2'(m_state[k])) begin errors++; $display("[TB] FAIL drop_model inst%0d got cnt=%0d state=%0d exp cnt=%0d state=%0d", k, o_cnt[k][3], o_state[k], m_cnt[k][3], m_state[k]); end
    end
    a = 4'hF;
  endtask

  task automatic test_async_reset();
    rearm();
    mode = 8'h00; a = 4'b1011; b = 4'hF;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_state[k] !== 2'd0 || o_scnt[k] !== 16'd0) begin errors++; $display("[TB] FAIL arst_state inst%0d got state=%0d scnt=%0d exp 0", k, o_state[k], o_scnt[k]); end
      checks++; if (o_cnt[k][2] !== 8'd0 || o_any[k] !== 1'b0 || o_pulse[k] !== 4'd0) begin errors++; $display("[TB] FAIL arst_stats inst%0d got cnt=%0d any=%0b pulse=%0h exp 0", k, o_cnt[k][2], o_any[k], o_pulse[k]); end
      checks++; if (o_fts[k] !== 16'd0 || o_fch[k] !== 2'd0) begin errors++; $display("[TB] FAIL arst_first inst%0d got ch=%0d ts=%0d exp 0", k, o_fch[k], o_fts[k]); end
    end
    model_reset();
    a = 4'hF;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clear_violation();
    rearm();
    mode = 8'h00; a = 4'b1110; b = 4'hF; clear = 1'b1;
    tick();
    clear = 1'b0; a = 4'hF;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_cnt[k][0] !== 8'd0 || o_pulse[k] !== 4'd0 || o_any[k] !== 1'b0) begin errors++; $display("[TB] FAIL clrv_stats inst%0d got cnt=%0d pulse=%0h any=%0b exp 0", k, o_cnt[k][0], o_pulse[k], o_any[k]); end
      checks++; if (o_state[k] !== 2'd2 || o_scnt[k] !== 16'd0) begin errors++; $display("[TB] FAIL clrv_state inst%0d got state=%0d scnt=%0d exp 2 0", k, o_state[k], o_scnt[k]); end
    end
    tick();
    checks++; if (o_scnt[0] !== 16'd1) begin errors++; $display("[TB] FAIL clrv_resume got %0d exp 1", o_scnt[0]); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      arm   = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 24) == 0);
      mode  = 8'($urandom);
      a     = 4'($urandom);
      b     = 4'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++; if (o_state[k] !== 2'(m_state[k])) begin errors++; $display("[TB] FAIL rnd_state inst%0d cyc%0d got %0d exp %0d", k, cyc, o_state[k], m_state[k]); end
        checks++; if (o_scnt[k] !== 16'(m_scnt[k])) begin errors++; $display("[TB] FAIL rnd_scnt inst%0d cyc%0d got %0d exp %0d", k, cyc, o_scnt[k], m_scnt[k]); end
        checks++; if (o_pulse[k] !== m_pulse[k]) begin errors++; $display("[TB] FAIL rnd_pulse inst%0d cyc%0d got %0h exp %0h", k, cyc, o_pulse[k], m_pulse[k]); end
        checks++; if (o_sticky[k] !== m_sticky[k] || o_any[k] !== (|m_sticky[k])) begin errors++; $display("[TB] FAIL rnd_sticky inst%0d cyc%0d got %0h/%0b exp %0h", k, cyc, o_sticky[k], o_any[k], m_sticky[k]); end
        checks++; if (o_fch[k] !== 2'(m_fch[k]) || o_fts[k] !== 16'(m_fts[k])) begin errors++; $display("[TB] FAIL rnd_first inst%0d cyc%0d got ch=%0d ts=%0d exp ch=%0d ts=%0d", k, cyc, o_fch[k], o_fts[k], m_fch[k], m_fts[k]); end
        for (int i = 0; i < 4; i++) begin
          checks++; if (o_cnt[k][i] !== 8'(m_cnt[k][i])) begin errors++; $display("[TB] FAIL rnd_cnt inst%0d ch%0d cyc%0d got %0d exp %0d", k, i, cyc, o_cnt[k][i], m_cnt[k][i]); end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; arm = 1'b0; clear = 1'b0; mode = 8'h00; a = 4'h0; b = 4'h0;
    model_reset();
    test_reset();
    test_all_pass();
    test_first_fail();
    test_simultaneous();
    test_saturation();
    test_halt();
    test_arm_drop();
    test_async_reset();
    test_clear_violation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
